// File: rtl/uart_send_buf.sv
// Buffered 8N1 UART transmitter: bytes are queued in a small FIFO and serialised LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_send_buf #(
    parameter int CLK_FREQ   = 100_000000,
    parameter int UART_BPS   = 128000,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_wr,
    output logic             tx_full,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] fifo_count,
    output logic             uart_txd
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int PTR_W   = CNT_W - 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, busy_q, done_q, txd_q;
    logic              txd_d, done_d;
    logic              pop_s, push_s, baud_last_s;
    logic [7:0]        mem_q [FIFO_DEPTH];

    assign baud_last_s = (baud_q == BAUD_LAST);
    // A full FIFO still accepts a write in the cycle the transmitter pops the head.
    assign push_s      = tx_wr && ((count_q != DEPTH_C) || pop_s);

    // Frame sequencing: bit timing, bit index and head-of-queue pop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop_s   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = {BAUD_W{1'b0}};
                bit_d  = 3'd0;
                if (count_q != {CNT_W{1'b0}}) begin
                    pop_s   = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the current state one clock later, so uart_txd is glitch-free.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_q[bit_q];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = ^shreg_q;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= {BAUD_W{1'b0}};
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            busy_q   <= (state_d != ST_IDLE) || (count_d != {CNT_W{1'b0}});
            done_q   <= done_d;
            txd_q    <= txd_d;
        end
    end

    assign tx_full    = full_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign fifo_count = count_q;
    assign uart_txd   = txd_q;
endmodule

// File: tb/tb_uart_send_buf.sv
// Randomised bench for uart_send_buf: a queue-and-frame-timer reference model predicts every output each clock.
module tb_uart_send_buf;
    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME    = 11 * BPS;
`else
    localparam int FRAME    = 10 * BPS;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full, tx_busy, tx_done, uart_txd;
    logic [4:0] fifo_count;

    uart_send_buf #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .FIFO_DEPTH(DEPTH), .CNT_W(5)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done),
        .fifo_count(fifo_count), .uart_txd(uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: pending bytes, byte on the line, clocks left in the current frame.
    logic [7:0] q[$];
    logic [7:0] cur_byte = 8'h00;
    int         tmr = 0;
    logic       txd_exp = 1'b1;
    logic       done_exp = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Level the line carries at position p (clocks) within a frame of byte b.
    function automatic logic line_bit(input int p, input logic [7:0] b);
        int k;
        k = p / BPS;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_edge(input logic wr, input logic [7:0] d);
        logic pop;
        txd_exp  = (tmr > 0) ? line_bit(FRAME - tmr, cur_byte) : 1'b1;
        done_exp = (tmr == 1);
        pop = (tmr == 0) && (q.size() > 0);
        if (tmr > 0) begin
            tmr--;
        end else if (pop) begin
            cur_byte = q.pop_front();
            tmr = FRAME;
        end
        if (wr && (q.size() < DEPTH || pop)) q.push_back(d);
    endtask

    task automatic check_all();
        chk_eq("uart_txd", uart_txd, txd_exp);
        chk_eq("tx_done", tx_done, done_exp);
        chk_eq("fifo_count", fifo_count, q.size());
        chk_eq("tx_full", tx_full, q.size() == DEPTH);
        chk_eq("tx_busy", tx_busy, (tmr > 0) || (q.size() > 0));
    endtask

    task automatic step(input logic wr, input logic [7:0] d);
        tx_wr = wr;
        tx_data = d;
        @(posedge sys_clk);
        model_edge(wr, d);
        #1;
        check_all();
        @(negedge sys_clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((tmr > 0 || q.size() > 0) && n < 20000) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk_eq("drain_timeout", (n >= 20000), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    endtask

    initial begin
        int n;
        // Reset values while reset is held.
        repeat (3) @(negedge sys_clk);
        chk_eq("rst_txd", uart_txd, 1'b1);
        chk_eq("rst_full", tx_full, 1'b0);
        chk_eq("rst_busy", tx_busy, 1'b0);
        chk_eq("rst_done", tx_done, 1'b0);
        chk_eq("rst_count", fifo_count, 5'd0);
        sys_rst_n = 1'b1;
        repeat (2) step(1'b0, 8'h00);

        // Single byte.
        step(1'b1, 8'hA5);
        drain();

        // Three consecutive writes.
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        drain();

        // Overflow: 20 consecutive writes, 17..19 dropped.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i));
        drain();

        // Write while full in the cycle the head is popped.
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h40 + i));
        n = 0;
        while (!(tmr == 0 && q.size() == DEPTH) && n < 2000) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk_eq("pop_wait_timeout", (n >= 2000), 1'b0);
        step(1'b1, 8'hEE);
        chk_eq("full_pop_write_count", fifo_count, 5'd16);
        drain();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) step(1'b1, 8'($urandom));
            end else begin
                step(($urandom_range(0, 99) < 3), 8'($urandom));
            end
        end
        drain();

        // Asynchronous reset in the middle of the data bits of 0x55.
        step(1'b1, 8'h55);
        step(1'b1, 8'h66);
        n = 0;
        while (!(tmr > 0 && tmr == FRAME - 4 * BPS - 3) && n < 500) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk_eq("mid_frame_timeout", (n >= 500), 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_eq("async_rst_txd", uart_txd, 1'b1);
        chk_eq("async_rst_count", fifo_count, 5'd0);
        chk_eq("async_rst_busy", tx_busy, 1'b0);
        q.delete();
        tmr = 0;
        @(negedge sys_clk);
        repeat (3) step(1'b0, 8'h00);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 8'h00);

        // A final byte after recovery.
        step(1'b1, 8'h07);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
